// File: rtl/i2c_byte_shifter_if.sv
// Byte-level I2C shifter bus: control/handshake from the sequencer and memory
// block, pin levels in, pin pull-downs and byte results out.
interface i2c_byte_shifter_if;
    logic       start;
    logic       rw;
    logic       nack;
    logic       rel;
    logic [7:0] din;
    logic       sda_in;
    logic       scl_in;
    logic       mem_oe;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       dout_vld;
    logic [7:0] dout;
    logic       ack_err;

    modport master (
        output start, rw, nack, rel, din, sda_in, scl_in,
        input  mem_oe, scl_oe, sda_oe, busy, done, dout_vld, dout, ack_err
    );

    modport slave (
        input  start, rw, nack, rel, din, sda_in, scl_in,
        output mem_oe, scl_oe, sda_oe, busy, done, dout_vld, dout, ack_err
    );
endinterface

// File: rtl/i2c_byte_shifter.sv
// Runs the nine SCL bit periods (8 data MSB first + ACK) of one I2C byte, TX or RX.
// Define I2C_CLK_STRETCH_EN to let a slave hold SCL low and stretch the high phase.
module i2c_byte_shifter #(
    parameter int unsigned DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    i2c_byte_shifter_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_LO, S_BIT_HI, S_END} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rw_q, rw_d;
    logic             nack_q, nack_d;
    logic             ack_q, ack_d;
    logic             mem_oe_q, mem_oe_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dout_vld_q, dout_vld_d;
    logic [7:0]       dout_q, dout_d;
    logic             ack_err_q, ack_err_d;

    logic stall, phase_end, last_bit, sample;

`ifdef I2C_CLK_STRETCH_EN
    assign stall = (state_q == S_BIT_HI) && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign stall         = 1'b0;
`endif

    assign phase_end = (cnt_q == CNT_W'(DIV - 1)) && !stall;
    assign last_bit  = (bit_idx_q == 4'd8);
    assign sample    = (state_q == S_BIT_HI) && phase_end;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD;
            S_LOAD:   state_d = S_BIT_LO;
            S_BIT_LO: if (phase_end) state_d = S_BIT_HI;
            S_BIT_HI: if (phase_end) state_d = last_bit ? S_END : S_BIT_LO;
            S_END:    if (phase_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        cnt_d      = '0;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        ack_d      = ack_q;
        sda_oe_d   = 1'b0;
        scl_oe_d   = scl_oe_q;

        if (state_q == S_IDLE && bus.start) begin
            rw_d   = bus.rw;
            nack_d = bus.nack;
        end

        if (state_q inside {S_BIT_LO, S_BIT_HI, S_END})
            cnt_d = phase_end ? '0 : (stall ? cnt_q : cnt_q + CNT_W'(1));

        if (state_q == S_LOAD) begin
            bit_idx_d = 4'd0;
            if (!rw_q) shreg_d = bus.din;
        end

        // TX shifts its own echoed bit in harmlessly; RX accumulates the byte.
        if (sample && !last_bit) begin
            shreg_d   = {shreg_q[6:0], bus.sda_in};
            bit_idx_d = bit_idx_q + 4'd1;
        end
        if (sample && last_bit) ack_d = bus.sda_in;

        done_d     = (state_q == S_END) && phase_end;
        dout_vld_d = done_d && rw_q;
        dout_d     = dout_vld_d ? shreg_q : dout_q;
        ack_err_d  = done_d ? (!rw_q && ack_q) : ack_err_q;
        mem_oe_d   = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);

        unique case (state_d)
            S_IDLE:   if (state_q == S_IDLE && bus.rel) scl_oe_d = 1'b0;
            S_LOAD:   scl_oe_d = scl_oe_q;
            S_BIT_LO: begin
                scl_oe_d = 1'b1;
                if (state_q != S_BIT_LO)
                    sda_oe_d = (bit_idx_d == 4'd8) ? (rw_q & ~nack_q)
                                                   : (~rw_q & ~shreg_d[7]);
                else
                    sda_oe_d = sda_oe_q;
            end
            S_BIT_HI: begin
                scl_oe_d = 1'b0;
                sda_oe_d = sda_oe_q;
            end
            S_END:    scl_oe_d = 1'b1;
            default:  scl_oe_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath flops are
    // reset too so an aborted transfer leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            ack_q      <= 1'b0;
            mem_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_q     <= 8'h00;
            ack_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            ack_q      <= ack_d;
            mem_oe_q   <= mem_oe_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dout_vld_q <= dout_vld_d;
            dout_q     <= dout_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.mem_oe   = mem_oe_q;
    assign bus.scl_oe   = scl_oe_q;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.dout     = dout_q;
    assign bus.ack_err  = ack_err_q;
endmodule

// File: tb/tb_i2c_byte_shifter.sv
// Randomised bench for i2c_byte_shifter against a cycle-window model of one byte
// transfer; honours I2C_CLK_STRETCH_EN when computing expected latency.
module tb_i2c_byte_shifter;
    localparam int DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    i2c_byte_shifter_if bus();

    i2c_byte_shifter #(.DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         scl_held = 1'b0;
    logic [7:0] last_dout = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle offset (from the start cycle) where bit b's SCL-low phase begins.
    function automatic int lo_start(input int b, input int extra);
        return 2 + 2 * b * DIV + ((b >= 3) ? extra : 0);
    endfunction

    function automatic int bit_at(input int k, input int extra);
        int r = -1;
        for (int b = 0; b < 9; b++)
            if (k >= lo_start(b, extra) && k < lo_start(b + 1, extra)) r = b;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_oe"},   bus.mem_oe,   1'b0);
        check({tag, "_scl_oe"},   bus.scl_oe,   1'b0);
        check({tag, "_sda_oe"},   bus.sda_oe,   1'b0);
        check({tag, "_busy"},     bus.busy,     1'b0);
        check({tag, "_done"},     bus.done,     1'b0);
        check({tag, "_dout_vld"}, bus.dout_vld, 1'b0);
        check({tag, "_dout"},     bus.dout,     8'h00);
        check({tag, "_ack_err"},  bus.ack_err,  1'b0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the done cycle,
    // so a following call starts back-to-back.
    task automatic run_xfer(input bit rw, input bit nack, input logic [7:0] din,
                            input logic [7:0] sbyte, input bit sack,
                            input int stall_len, input bit rel_too, input bit junk);
        int         extra    = STRETCH ? stall_len : 0;
        int         done_exp = 2 + 19 * DIV + extra;
        int         hi2      = lo_start(2, 0) + DIV;
        int         done_k   = -1;
        int         mem_cnt  = 0;
        int         b;
        logic [8:0] sda_exp  = rw ? {8'h00, ~nack} : {~din, 1'b0};
        logic [8:0] sda_seen = '0;

        bus.start = 1'b1; bus.rw = rw; bus.nack = nack; bus.din = din; bus.rel = rel_too;
        for (int k = 1; k <= done_exp + 20 && done_k < 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.rel   = 1'b0;
            if (k >= 2 || rw) bus.din = 8'($urandom);
            b = bit_at(k, extra);
            if (b < 0)      bus.sda_in = 1'b1;
            else if (b < 8) bus.sda_in = rw ? sbyte[7-b] : 1'b1;
            else            bus.sda_in = rw ? 1'b1 : sack;
            bus.scl_in = !(stall_len > 0 && k >= hi2 && k < hi2 + stall_len);
            if (junk && k >= 2 && k <= done_exp - 2) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.rel   = ($urandom_range(0, 3) == 0);
            end

            if (bus.mem_oe) mem_cnt++;
            if (k == 1) check("mem_oe_load", bus.mem_oe, 1'b1);
            if (b >= 0 && k == lo_start(b, extra)) begin
                sda_seen[8-b] = bus.sda_oe;
                check("scl_oe_low_phase", bus.scl_oe, 1'b1);
            end
            if (b >= 0 && k == lo_start(b + 1, extra) - 1) begin
                check("sda_oe_hold_high_phase", bus.sda_oe, sda_exp[8-b]);
                check("scl_oe_high_phase", bus.scl_oe, 1'b0);
            end
            if (k == done_exp - 1) check("busy_before_done", bus.busy, 1'b1);
            if (bus.done) done_k = k;
        end

        check("done_cycle", done_k, done_exp);
        check("sda_oe_pattern", sda_seen, sda_exp);
        check("mem_oe_one_cycle", mem_cnt, 1);
        if (done_k > 0) begin
            check("busy_at_done", bus.busy, 1'b0);
            check("dout_vld_at_done", bus.dout_vld, rw);
            check("scl_oe_held_at_done", bus.scl_oe, 1'b1);
            check("sda_oe_at_done", bus.sda_oe, 1'b0);
            if (rw) begin
                last_dout = sbyte;
            end else begin
                check("ack_err", bus.ack_err, sack);
            end
            check("dout", bus.dout, last_dout);
        end
        scl_held = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", bus.done, 1'b0);
            check("idle_busy", bus.busy, 1'b0);
            check("idle_scl_oe", bus.scl_oe, scl_held);
        end
    endtask

    task automatic rel_pulse();
        bus.rel = 1'b1;
        @(negedge clk);
        bus.rel = 1'b0;
        check("rel_scl_oe", bus.scl_oe, 1'b0);
        check("rel_sda_oe", bus.sda_oe, 1'b0);
        scl_held = 1'b0;
    endtask

    task automatic abort_test();
        int done_seen = 0;
        int k_abort   = lo_start(4, 0) + 1;
        bus.start = 1'b1; bus.rw = 1'b0; bus.nack = 1'b0; bus.din = 8'($urandom);
        for (int k = 1; k < k_abort; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("abort");
        scl_held  = 1'b0;
        last_dout = 8'h00;
        for (int i = 0; i < 19 * DIV + 8; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_busy", bus.busy, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.nack = 1'b0; bus.rel = 1'b0;
        bus.din = 8'h00; bus.sda_in = 1'b1; bus.scl_in = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);

        run_xfer(1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1'b0, 1'b0);
        idle(3);
        run_xfer(1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b0, 8'h00, 8'h96, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        rel_pulse();
        idle(2);
        run_xfer(1'b1, 1'b1, 8'hFF, 8'h5A, 1'b1, 0, 1'b1, 1'b0);
        run_xfer(1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 10, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 8'h81, 8'h00, 1'b1, 0, 1'b0, 1'b1);
        idle(1);
        abort_test();
        run_xfer(1'b0, 1'b0, 8'h7E, 8'h00, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_xfer(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0,
                     1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) rel_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
